// File: rtl/bus_pkg.sv
// ----------------------------------------------------------------------------
// bus_pkg
// Shared types and constants for the bus fabric and its run/halt/step
// controller.
//   halt_state_t : controller states (RUN, HALT, STEP)
//   SRC_*        : bus source slot indices
//   count_ones   : number of set bits in a 32-bit vector
// ----------------------------------------------------------------------------
package bus_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HALT = 2'd1,
      STEP = 2'd2
   } halt_state_t;

   localparam int SRC_ALU = 0;
   localparam int SRC_IO  = 1;
   localparam int SRC_REG = 2;
   localparam int SRC_RAM = 3;
   localparam int SRC_PC  = 4;

   function automatic int unsigned count_ones(input logic [31:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 32; i++) begin
         if (v[i]) n++;
      end
      return n;
   endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// ----------------------------------------------------------------------------
// btn_sync_edge
// Two-flop synchroniser followed by a rising-edge detector for an
// asynchronous pushbutton. Every flop resets to 1, so a button that is held
// down while reset is released produces no pulse.
//   clk_i   : system clock
//   rst_ni  : asynchronous reset, active-low
//   pin_i   : raw asynchronous button level
//   pulse_o : one-cycle pulse, high in the 2nd cycle after the pin is first
//             sampled high (acted on at the 3rd edge after the pin rises)
// ----------------------------------------------------------------------------
module btn_sync_edge (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic pin_i,
   output logic pulse_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   // NOTE: non-blocking assignments make each flop capture the previous
   // stage's old value, which is what turns these lines into a shift chain.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= pin_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/bus_ctrl.sv
// ----------------------------------------------------------------------------
// bus_ctrl
// NSRC-way shared-bus selector with keeper and sticky contention detection,
// plus a RUN/HALT/STEP controller producing the datapath clock enable.
//   i_clk, i_reset     : clock, asynchronous active-low reset
//   i_srcData          : source s drives bits [s*WIDTH +: WIDTH]
//   i_srcNOe           : per-source output enable, active-low
//   o_bus              : resolved bus (keeper when nobody drives, wired-OR
//                        when several drive)
//   o_busDriven        : at least one source enabled
//   o_contention       : sticky, more than one source enabled on an enabled
//                        cycle
//   o_contentionSrc    : enable mask captured at the latest contention
//   i_clrContention    : clears flag and mask (a same-cycle contention wins)
//   i_ctrlHlt          : halt request from the control unit
//   i_button, i_step   : asynchronous resume / single-step pushbuttons
//   o_clkEn            : clock enable for all datapath registers
//   o_halted           : controller is in HALT
// ----------------------------------------------------------------------------
module bus_ctrl
   import bus_pkg::*;
#(
   parameter int WIDTH              = 16,
   parameter int NSRC               = 5,
   parameter bit HALT_ON_CONTENTION = 1'b1
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic [NSRC*WIDTH-1:0]   i_srcData,
   input  logic [NSRC-1:0]         i_srcNOe,
   output logic [WIDTH-1:0]        o_bus,
   output logic                    o_busDriven,
   output logic                    o_contention,
   output logic [NSRC-1:0]         o_contentionSrc,
   input  logic                    i_clrContention,
   input  logic                    i_ctrlHlt,
   input  logic                    i_button,
   input  logic                    i_step,
   output logic                    o_clkEn,
   output logic                    o_halted
);

   // ------------------------------------------------------------------ bus
   logic [NSRC-1:0]  en;
   int unsigned      n_en;
   logic [WIDTH-1:0] wired_or;
   logic [WIDTH-1:0] keeper_q;
   logic             bus_driven;
   logic             clk_en;
   logic             contention_now;

   assign en = ~i_srcNOe;

   // With a single driver the OR reduces to that driver's data, so one
   // expression covers both the normal and the contention case.
   // NOTE: every variable written in an always_comb gets a value before any
   // conditional update; otherwise synthesis infers a latch to hold it.
   always_comb begin
      wired_or = '0;
      for (int s = 0; s < NSRC; s++) begin
         if (en[s]) wired_or = wired_or | i_srcData[s*WIDTH +: WIDTH];
      end
   end

   always_comb n_en = count_ones(32'(en));

   assign bus_driven     = |en;
   assign o_bus          = bus_driven ? wired_or : keeper_q;
   assign o_busDriven    = bus_driven;
   assign contention_now = clk_en && (n_en > 1);

   // Keeper and contention capture only advance on enabled cycles, so a
   // halted datapath sees a frozen bus history.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         keeper_q        <= '0;
         o_contention    <= 1'b0;
         o_contentionSrc <= '0;
      end else begin
         if (clk_en && bus_driven) keeper_q <= o_bus;
         if (contention_now) begin
            o_contention    <= 1'b1;
            o_contentionSrc <= en;
         end else if (i_clrContention) begin
            o_contention    <= 1'b0;
            o_contentionSrc <= '0;
         end
      end
   end

   // -------------------------------------------------------------- buttons
   logic btn_p;
   logic step_p;

   btn_sync_edge u_btn_sync (
      .clk_i   (i_clk),
      .rst_ni  (i_reset),
      .pin_i   (i_button),
      .pulse_o (btn_p)
   );

   btn_sync_edge u_step_sync (
      .clk_i   (i_clk),
      .rst_ni  (i_reset),
      .pin_i   (i_step),
      .pulse_o (step_p)
   );

   // ------------------------------------------------------------------ FSM
   halt_state_t state_q;
   halt_state_t state_d;
   logic        ignore_q;
   logic        ignore_d;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q  <= RUN;
         ignore_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ignore_q <= ignore_d;
      end
   end

   // ignore is armed when leaving HALT and dropped after the first enabled
   // cycle, so the halt control word still sitting on i_ctrlHlt cannot
   // re-halt the machine before it has executed a single cycle.
   always_comb begin
      state_d  = state_q;
      ignore_d = clk_en ? 1'b0 : ignore_q;
      case (state_q)
         RUN: begin
            if ((i_ctrlHlt && !ignore_q) ||
                (HALT_ON_CONTENTION && contention_now)) begin
               state_d = HALT;
            end
         end
         HALT: begin
            if (btn_p) begin
               state_d  = RUN;
               ignore_d = 1'b1;
            end else if (step_p) begin
               state_d  = STEP;
               ignore_d = 1'b1;
            end
         end
         STEP:    state_d = HALT;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      clk_en   = 1'b1;
      o_halted = 1'b0;
      if (state_q == HALT) begin
         clk_en   = 1'b0;
         o_halted = 1'b1;
      end
   end

   assign o_clkEn = clk_en;

endmodule

// File: tb/tb_bus_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bus_ctrl
// Self-checking bench for bus_ctrl: directed scenarios followed by a
// randomized run compared against a behavioural model of the bus fabric and
// the run/halt/step controller.
// ----------------------------------------------------------------------------
module tb_bus_ctrl;
   import bus_pkg::*;

   localparam int W = 16;
   localparam int N = 5;
   localparam bit HOC = 1'b1;

   logic             i_clk;
   logic             i_reset;
   logic [N*W-1:0]   i_srcData;
   logic [N-1:0]     i_srcNOe;
   logic [W-1:0]     o_bus;
   logic             o_busDriven;
   logic             o_contention;
   logic [N-1:0]     o_contentionSrc;
   logic             i_clrContention;
   logic             i_ctrlHlt;
   logic             i_button;
   logic             i_step;
   logic             o_clkEn;
   logic             o_halted;

   int n_checks = 0;
   int n_errors = 0;

   bus_ctrl #(.WIDTH(W), .NSRC(N), .HALT_ON_CONTENTION(HOC)) dut (
      .i_clk           (i_clk),
      .i_reset         (i_reset),
      .i_srcData       (i_srcData),
      .i_srcNOe        (i_srcNOe),
      .o_bus           (o_bus),
      .o_busDriven     (o_busDriven),
      .o_contention    (o_contention),
      .o_contentionSrc (o_contentionSrc),
      .i_clrContention (i_clrContention),
      .i_ctrlHlt       (i_ctrlHlt),
      .i_button        (i_button),
      .i_step          (i_step),
      .o_clkEn         (o_clkEn),
      .o_halted        (o_halted)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // ------------------------------------------------------------ model
   logic [W-1:0] m_keeper;
   bit           m_cont;
   logic [N-1:0] m_mask;
   string        m_mode;
   bit           m_ign;
   bit           bh [3];   // button pin as sampled 1, 2, 3 edges ago
   bit           sh [3];

   task automatic model_reset();
      m_keeper = '0;
      m_cont   = 1'b0;
      m_mask   = '0;
      m_mode   = "RUN";
      m_ign    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bh[i] = 1'b1;
         sh[i] = 1'b1;
      end
   endtask

   function automatic int m_drivers();
      int n;
      n = 0;
      for (int s = 0; s < N; s++) if (!i_srcNOe[s]) n++;
      return n;
   endfunction

   function automatic logic [W-1:0] m_bus();
      logic [W-1:0] v;
      v = '0;
      if (m_drivers() == 0) return m_keeper;
      for (int s = 0; s < N; s++) if (!i_srcNOe[s]) v |= i_srcData[s*W +: W];
      return v;
   endfunction

   function automatic bit m_enabled();
      return m_mode != "HALT";
   endfunction

   // One rising edge of the reference behaviour, using the inputs present.
   task automatic model_edge();
      bit    en_now, cont_now, bp, sp, ni;
      string nm;
      int    n;
      if (!i_reset) begin
         model_reset();
         return;
      end
      en_now   = m_enabled();
      n        = m_drivers();
      cont_now = en_now && (n > 1);
      // a press acts on the 3rd edge after the pin rises
      bp = bh[1] && !bh[2];
      sp = sh[1] && !sh[2];
      nm = m_mode;
      ni = en_now ? 1'b0 : m_ign;
      if (m_mode == "RUN") begin
         if ((i_ctrlHlt && !m_ign) || (HOC && cont_now)) nm = "HALT";
      end else if (m_mode == "HALT") begin
         if (bp) begin
            nm = "RUN";
            ni = 1'b1;
         end else if (sp) begin
            nm = "STEP";
            ni = 1'b1;
         end
      end else begin
         nm = "HALT";
      end
      if (en_now && n > 0) m_keeper = m_bus();
      if (cont_now) begin
         m_cont = 1'b1;
         m_mask = ~i_srcNOe;
      end else if (i_clrContention) begin
         m_cont = 1'b0;
         m_mask = '0;
      end
      bh[2] = bh[1]; bh[1] = bh[0]; bh[0] = i_button;
      sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = i_step;
      m_mode = nm;
      m_ign  = ni;
   endtask

   task automatic tick();
      @(posedge i_clk);
      model_edge();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // --------------------------------------------------------- scenarios
   task automatic test_reset();
      i_reset         = 1'b0;
      i_srcData       = '0;
      i_srcNOe        = '1;
      i_clrContention = 1'b0;
      i_ctrlHlt       = 1'b0;
      i_button        = 1'b0;
      i_step          = 1'b0;
      model_reset();
      #2;
      n_checks++; if (o_bus !== 16'h0000) begin n_errors++; $display("FAIL reset_bus: got %h want 0000", o_bus); end
      n_checks++; if (o_busDriven !== 1'b0) begin n_errors++; $display("FAIL reset_driven: got %b want 0", o_busDriven); end
      n_checks++; if (o_contention !== 1'b0) begin n_errors++; $display("FAIL reset_cont: got %b want 0", o_contention); end
      n_checks++; if (o_contentionSrc !== 5'b0) begin n_errors++; $display("FAIL reset_mask: got %b want 00000", o_contentionSrc); end
      n_checks++; if (o_clkEn !== 1'b1) begin n_errors++; $display("FAIL reset_clken: got %b want 1", o_clkEn); end
      n_checks++; if (o_halted !== 1'b0) begin n_errors++; $display("FAIL reset_halted: got %b want 0", o_halted); end
      idle(2);
      i_reset = 1'b1;
      idle(4);
   endtask

   task automatic test_single_source();
      i_srcData = {$urandom, $urandom, $urandom};
      i_srcData[SRC_ALU*W +: W] = 16'h1234;
      i_srcNOe = 5'b11110;
      #1;
      n_checks++; if (o_bus !== 16'h1234) begin n_errors++; $display("FAIL single_bus: got %h want 1234", o_bus); end
      n_checks++; if (o_busDriven !== 1'b1) begin n_errors++; $display("FAIL single_driven: got %b want 1", o_busDriven); end
      tick();
      i_srcNOe = 5'b11111;
      i_srcData = {$urandom, $urandom, $urandom};
      #1;
      n_checks++; if (o_bus !== 16'h1234) begin n_errors++; $display("FAIL keeper_bus: got %h want 1234", o_bus); end
      n_checks++; if (o_busDriven !== 1'b0) begin n_errors++; $display("FAIL keeper_driven: got %b want 0", o_busDriven); end
      tick();
   endtask

   task automatic test_contention();
      i_srcData = '0;
      i_srcData[SRC_IO*W +: W]  = 16'h00F0;
      i_srcData[SRC_RAM*W +: W] = 16'h0F00;
      i_srcNOe = 5'b10101;
      #1;
      n_checks++; if (o_bus !== 16'h0FF0) begin n_errors++; $display("FAIL cont_bus: got %h want 0ff0", o_bus); end
      tick();
      i_srcNOe = 5'b11111;
      n_checks++; if (o_contention !== 1'b1) begin n_errors++; $display("FAIL cont_flag: got %b want 1", o_contention); end
      n_checks++; if (o_contentionSrc !== 5'b01010) begin n_errors++; $display("FAIL cont_mask: got %b want 01010", o_contentionSrc); end
      n_checks++; if (o_halted !== 1'b1) begin n_errors++; $display("FAIL cont_halt: got %b want 1", o_halted); end
      // resume, then contend and clear in the same enabled cycle
      i_button = 1'b1;
      idle(2);
      n_checks++; if (o_clkEn !== 1'b0) begin n_errors++; $display("FAIL cont_resume_early: got %b want 0", o_clkEn); end
      tick();
      n_checks++; if (o_clkEn !== 1'b1) begin n_errors++; $display("FAIL cont_resume: got %b want 1", o_clkEn); end
      i_srcNOe = 5'b11100;
      i_clrContention = 1'b1;
      tick();
      i_srcNOe = 5'b11111;
      i_button = 1'b0;
      n_checks++; if (o_contention !== 1'b1) begin n_errors++; $display("FAIL setclr_flag: got %b want 1", o_contention); end
      n_checks++; if (o_contentionSrc !== 5'b00011) begin n_errors++; $display("FAIL setclr_mask: got %b want 00011", o_contentionSrc); end
      tick();
      i_clrContention = 1'b0;
      n_checks++; if (o_contention !== 1'b0) begin n_errors++; $display("FAIL clr_flag: got %b want 0", o_contention); end
      n_checks++; if (o_contentionSrc !== 5'b0) begin n_errors++; $display("FAIL clr_mask: got %b want 00000", o_contentionSrc); end
      // still halted from the second contention; resume to RUN
      idle(3);
      i_button = 1'b1;
      idle(3);
      i_button = 1'b0;
      n_checks++; if (o_halted !== 1'b0) begin n_errors++; $display("FAIL cont_rerun: got %b want 0", o_halted); end
      idle(3);
   endtask

   task automatic test_halt_resume();
      i_ctrlHlt = 1'b1;
      #1;
      n_checks++; if (o_clkEn !== 1'b1) begin n_errors++; $display("FAIL hlt_current: got %b want 1", o_clkEn); end
      tick();
      n_checks++; if (o_clkEn !== 1'b0) begin n_errors++; $display("FAIL hlt_next: got %b want 0", o_clkEn); end
      idle(2);
      i_button = 1'b1;
      idle(2);
      n_checks++; if (o_clkEn !== 1'b0) begin n_errors++; $display("FAIL resume_2nd: got %b want 0", o_clkEn); end
      tick();
      n_checks++; if (o_clkEn !== 1'b1) begin n_errors++; $display("FAIL resume_3rd: got %b want 1", o_clkEn); end
      tick();
      n_checks++; if (o_clkEn !== 1'b1) begin n_errors++; $display("FAIL resume_ignore: got %b want 1", o_clkEn); end
      tick();
      n_checks++; if (o_clkEn !== 1'b0) begin n_errors++; $display("FAIL rehalt: got %b want 0", o_clkEn); end
      i_ctrlHlt = 1'b0;
      i_button  = 1'b0;
      idle(3);
   endtask

   task automatic test_single_step();
      int           pulses;
      logic [W-1:0] data;
      logic [W-1:0] last_en;
      pulses  = 0;
      last_en = m_keeper;
      for (int p = 0; p < 3; p++) begin
         for (int c = 0; c < 6; c++) begin
            i_step = (c < 2);
            data = W'($urandom);
            i_srcData[SRC_ALU*W +: W] = data;
            i_srcNOe = 5'b11110;
            #1;
            n_checks++; if (o_clkEn !== m_enabled()) begin n_errors++; $display("FAIL step_clken: got %b want %b", o_clkEn, m_enabled()); end
            if (o_clkEn) begin
               pulses++;
               last_en = data;
            end
            tick();
         end
         i_srcNOe = 5'b11111;
         #1;
         n_checks++; if (o_bus !== last_en) begin n_errors++; $display("FAIL step_keeper: got %h want %h", o_bus, last_en); end
      end
      n_checks++; if (pulses !== 3) begin n_errors++; $display("FAIL step_pulses: got %0d want 3", pulses); end
   endtask

   task automatic test_both_buttons();
      n_checks++; if (o_halted !== 1'b1) begin n_errors++; $display("FAIL both_pre: got %b want 1", o_halted); end
      i_button = 1'b1;
      i_step   = 1'b1;
      idle(3);
      n_checks++; if (o_clkEn !== 1'b1) begin n_errors++; $display("FAIL both_c1: got %b want 1", o_clkEn); end
      tick();
      n_checks++; if (o_clkEn !== 1'b1) begin n_errors++; $display("FAIL both_c2: got %b want 1", o_clkEn); end
      tick();
      n_checks++; if (o_halted !== 1'b0) begin n_errors++; $display("FAIL both_run: got %b want 0", o_halted); end
      i_button = 1'b0;
      i_step   = 1'b0;
      idle(3);
   endtask

   task automatic test_reset_held_button();
      @(negedge i_clk);
      i_reset  = 1'b0;
      i_button = 1'b1;
      model_reset();
      idle(2);
      i_reset = 1'b1;
      idle(6);
      n_checks++; if (o_halted !== 1'b0) begin n_errors++; $display("FAIL held_noedge: got %b want 0", o_halted); end
      i_ctrlHlt = 1'b1;
      tick();
      i_ctrlHlt = 1'b0;
      n_checks++; if (o_halted !== 1'b1) begin n_errors++; $display("FAIL held_halt: got %b want 1", o_halted); end
      i_button = 1'b0;
      idle(3);
      i_button = 1'b1;
      idle(3);
      n_checks++; if (o_clkEn !== 1'b1) begin n_errors++; $display("FAIL held_repress: got %b want 1", o_clkEn); end
      i_button = 1'b0;
      idle(2);
      // contention halt, step once, then reset in the middle of STEP
      i_srcData[SRC_REG*W +: W] = 16'hA5A5;
      i_srcData[SRC_PC*W +: W]  = 16'h0101;
      i_srcNOe = 5'b01011;
      tick();
      i_srcNOe = 5'b11111;
      i_step = 1'b1;
      idle(3);
      n_checks++; if (o_clkEn !== 1'b1 || o_halted !== 1'b0) begin n_errors++; $display("FAIL in_step: got clken=%b halted=%b want 1/0", o_clkEn, o_halted); end
      n_checks++; if (o_contention !== 1'b1 || o_bus !== 16'hA5A5) begin n_errors++; $display("FAIL pre_rst: got cont=%b bus=%h want 1/a5a5", o_contention, o_bus); end
      i_reset = 1'b0;
      model_reset();
      #1;
      n_checks++; if (o_clkEn !== 1'b1) begin n_errors++; $display("FAIL rst_step_clken: got %b want 1", o_clkEn); end
      n_checks++; if (o_contention !== 1'b0) begin n_errors++; $display("FAIL rst_step_cont: got %b want 0", o_contention); end
      n_checks++; if (o_bus !== 16'h0000) begin n_errors++; $display("FAIL rst_step_keeper: got %h want 0000", o_bus); end
      i_step = 1'b0;
      idle(2);
      n_checks++; if (o_halted !== 1'b0) begin n_errors++; $display("FAIL rst_step_run: got %b want 0", o_halted); end
      i_reset = 1'b1;
      idle(4);
   endtask

   task automatic test_random();
      int r;
      for (int c = 0; c < 400; c++) begin
         i_srcData = {$urandom, $urandom, $urandom};
         r = $urandom_range(0, 99);
         if (r < 55)      i_srcNOe = '1;
         else if (r < 80) i_srcNOe = ~(5'(1) << $urandom_range(0, N-1));
         else             i_srcNOe = 5'($urandom);
         i_ctrlHlt       = ($urandom_range(0, 9) == 0);
         i_clrContention = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 5) == 0) i_button = ~i_button;
         if ($urandom_range(0, 5) == 0) i_step   = ~i_step;
         #1;
         n_checks++; if (o_bus !== m_bus()) begin n_errors++; $display("FAIL rnd_bus c%0d: got %h want %h", c, o_bus, m_bus()); end
         n_checks++; if (o_busDriven !== (m_drivers() > 0)) begin n_errors++; $display("FAIL rnd_driven c%0d: got %b", c, o_busDriven); end
         tick();
         n_checks++; if (o_contention !== m_cont) begin n_errors++; $display("FAIL rnd_cont c%0d: got %b want %b", c, o_contention, m_cont); end
         n_checks++; if (o_contentionSrc !== m_mask) begin n_errors++; $display("FAIL rnd_mask c%0d: got %b want %b", c, o_contentionSrc, m_mask); end
         n_checks++; if (o_clkEn !== m_enabled()) begin n_errors++; $display("FAIL rnd_clken c%0d: got %b want %b", c, o_clkEn, m_enabled()); end
         n_checks++; if (o_halted !== (m_mode == "HALT")) begin n_errors++; $display("FAIL rnd_halted c%0d: got %b want %s", c, o_halted, m_mode); end
      end
   endtask

   initial begin
      test_reset();
      test_single_source();
      test_contention();
      test_halt_resume();
      test_single_step();
      test_both_buttons();
      test_reset_held_button();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bus_ctrl.md
Name: bus_ctrl

Overview:
- Parametrised shared-bus fabric plus run/halt/step controller for the next CPU datapath generation.
- Replaces hand-wired multi-driver bus assigns with an explicit NSRC-way, WIDTH-bit, active-low-enabled source selector.
- Adds a bus keeper and sticky contention detection.
- Replaces the gated clock with a clock enable driven by a RUN/HALT/STEP state machine, with a single-step button.

Parameters:
- WIDTH, 16, bus width in bits.
- NSRC, 5, number of bus sources (ALU, IO, regs, RAM, PC).
- HALT_ON_CONTENTION, 1, when 1 a detected contention forces HALT.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous reset, active-low.
- i_srcData  in  NSRC*WIDTH  source s occupies bits [s*WIDTH +: WIDTH].
- i_srcNOe  in  NSRC  per-source output enable, active-low.
- o_bus  out  WIDTH  resolved bus value.
- o_busDriven  out  1  at least one source enabled this cycle.
- o_contention  out  1  sticky: more than one source enabled.
- o_contentionSrc  out  NSRC  active-high enable mask captured at the latest contention.
- i_clrContention  in  1  clears the sticky contention flag and mask.
- i_ctrlHlt  in  1  halt request from the control unit.
- i_button  in  1  asynchronous resume pushbutton.
- i_step  in  1  asynchronous single-step pushbutton.
- o_clkEn  out  1  clock enable for all datapath registers.
- o_halted  out  1  state is HALT.

Behaviour:
- Reset (i_reset=0, async) sets:
  - state RUN, o_clkEn=1, o_halted=0.
  - keeper=0, o_contention=0, o_contentionSrc=0, ignore flag=0.
  - all synchroniser and edge flops =1, so a button held through reset yields no edge.
- Bus resolution (combinational), with en = ~i_srcNOe:
  - zero enabled: o_bus = keeper, o_busDriven=0.
  - exactly one enabled: o_bus = that source's data.
  - more than one enabled: o_bus = bitwise OR of the enabled sources (wired-OR model).
- Keeper: on a rising edge with o_clkEn=1 and o_busDriven=1, keeper <= o_bus. Otherwise it holds.
- Contention: sampled on rising edges where o_clkEn=1 and popcount(en) > 1.
  - Sets o_contention=1 and loads o_contentionSrc=en. A later contention overwrites the mask.
  - i_clrContention=1 clears both on the next edge.
  - If set and clear occur in the same cycle, set wins (new mask is loaded).
- Button inputs: 2-flop synchroniser then rising-edge detect per input.
  - The pulse reaches the FSM on the 3rd edge after the pin rises.
  - Each press gives a one-cycle pulse btnP / stepP.
- FSM states are RUN, HALT, STEP. o_clkEn=1 in RUN and STEP, 0 in HALT.
- RUN transitions:
  - i_ctrlHlt=1 and ignore=0 → HALT next cycle. The current cycle completes with o_clkEn=1.
  - If HALT_ON_CONTENTION=1, a contention detected this cycle → HALT.
  - btnP and stepP are ignored in RUN.
- HALT transitions:
  - btnP → RUN, with ignore=1.
  - else stepP → STEP, with ignore=1.
  - btnP and stepP together: resume wins.
- STEP: exactly one cycle with o_clkEn=1, then → HALT unconditionally.
- ignore flag:
  - Masks i_ctrlHlt in the first enabled cycle after leaving HALT. The frozen halt control word must not re-halt immediately.
  - Cleared after that cycle.
- Contention-halt and ctrlHlt in the same cycle: single transition to HALT.
- Reset asserted mid-STEP or mid-HALT: immediate return to RUN. The keeper is cleared.

Decomposition:
- Package bus_pkg holds:
  - halt_state_t enum {RUN, HALT, STEP}.
  - source index constants SRC_ALU=0, SRC_IO=1, SRC_REG=2, SRC_RAM=3, SRC_PC=4.
- One sub-module, btn_sync_edge: 2-flop sync plus rising-edge pulse, reset to 1, instantiated twice.

Test Plan:
1. Reset then a single source:
   - Stimulus: i_srcNOe=5'b11110, src0=16'h1234.
   - Required: o_bus=16'h1234, o_busDriven=1. Next cycle with all NOe=1: o_bus=16'h1234 (keeper), o_busDriven=0.
2. Contention:
   - Stimulus: src1=16'h00F0, src3=16'h0F00, i_srcNOe=5'b10101.
   - Required: o_bus=16'h0FF0, and next edge o_contention=1, o_contentionSrc=5'b01010, o_halted=1.
   - Then set and clear in the same cycle: the new mask is retained.
3. Halt/resume:
   - Stimulus: i_ctrlHlt=1 held.
   - Required: o_clkEn=0 from the next cycle. Pulse i_button: o_clkEn=1 on the 3rd edge after the press, and i_ctrlHlt still high does not re-halt in that cycle; halt recurs on the following cycle.
4. Single step:
   - Stimulus: in HALT, press i_step 3 times.
   - Required: exactly 3 one-cycle o_clkEn pulses, and the keeper updates only on those cycles.
5. Button and step pressed simultaneously in HALT:
   - Required: RUN, with o_clkEn staying 1 beyond one cycle.
6. Button held through reset release:
   - Required: no edge and state stays RUN. Then i_ctrlHlt halts, and release followed by re-press resumes.
   - Also: async reset mid-STEP → o_clkEn=1, o_contention=0 immediately.
